// File: rtl/tdm_pkg.sv
// Shared types and constants for the two-lane TDM demultiplexer.
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } lane_state_t;

    localparam logic CH0           = 1'b0;
    localparam logic CH1           = 1'b1;
    localparam int   DEFAULT_WIDTH = 8;

endpackage

// File: rtl/tdm_demux_lane.sv
// One deserializer lane: MSB-first shift register, bit counter and word FSM.
// Optional trailing even-parity check when TDM_DEMUX_PARITY_EN is defined.
import tdm_pkg::*;

module tdm_demux_lane #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_bit,
    input  logic             i_sof,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SRW = WIDTH;
`else
    // The final data bit goes straight to the output, so one bit less is stored.
    localparam int SRW = WIDTH - 1;
`endif

    lane_state_t      r_state, w_state_nxt;
    logic [SRW-1:0]   r_sr, w_sr_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_word, w_word_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_drop, w_drop_nxt;
    logic [WIDTH-1:0] w_full;
`ifdef TDM_DEMUX_PARITY_EN
    logic             r_par, w_par_nxt;
`endif

    assign w_full = {r_sr[WIDTH-2:0], i_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_valid <= w_valid_nxt;
            r_drop  <= w_drop_nxt;
`ifdef TDM_DEMUX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_valid_nxt = 1'b0;
        w_drop_nxt  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        if (i_en) begin
            case (r_state)
                IDLE: begin
                    if (i_sof) begin
                        w_sr_nxt    = SRW'(i_bit);
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = COLLECT;
`ifdef TDM_DEMUX_PARITY_EN
                        w_par_nxt   = i_bit;
`endif
                    end
                end
                COLLECT: begin
                    if (i_sof) begin
                        // Restart: the sof bit becomes the MSB of a fresh word.
                        w_drop_nxt = 1'b1;
                        w_sr_nxt   = SRW'(i_bit);
                        w_cnt_nxt  = CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
                        w_par_nxt  = i_bit;
`endif
                    end else if (r_cnt == CW'(WIDTH - 1)) begin
                        w_cnt_nxt = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        w_sr_nxt    = w_full[SRW-1:0];
                        w_par_nxt   = r_par ^ i_bit;
                        w_state_nxt = PARITY;
`else
                        w_word_nxt  = w_full;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
`endif
                    end else begin
                        w_sr_nxt  = w_full[SRW-1:0];
                        w_cnt_nxt = r_cnt + CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
                        w_par_nxt = r_par ^ i_bit;
`endif
                    end
                end
`ifdef TDM_DEMUX_PARITY_EN
                PARITY: begin
                    // Any bit here is the parity bit, sof included.
                    if ((r_par ^ i_bit) == 1'b0) begin
                        w_word_nxt  = r_sr;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
`endif
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_drop  = r_drop;

endmodule

// File: rtl/tdm_demux.sv
// Two-lane TDM demultiplexer: routes each tagged serial bit to its lane deserializer.
// Optional per-word even parity: define TDM_DEMUX_PARITY_EN.
import tdm_pkg::*;

module tdm_demux #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic             in_bit,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    output logic [1:0]       drop
);

    logic w_en0, w_en1;
    logic w_drop0, w_drop1;

    assign w_en0 = in_valid & (in_sel == CH0);
    assign w_en1 = in_valid & (in_sel == CH1);

    tdm_demux_lane #(.WIDTH(WIDTH)) u_lane0 (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en0),
        .i_bit   (in_bit),
        .i_sof   (in_sof),
        .o_word  (out0),
        .o_valid (out0_valid),
        .o_drop  (w_drop0)
    );

    tdm_demux_lane #(.WIDTH(WIDTH)) u_lane1 (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_en1),
        .i_bit   (in_bit),
        .i_sof   (in_sof),
        .o_word  (out1),
        .o_valid (out1_valid),
        .o_drop  (w_drop1)
    );

    assign drop = {w_drop1, w_drop0};

endmodule
